divider_iterative: RTL

Multi-cycle 32-bit integer divider producing quotient and remainder with RV32M DIV/DIVU/REM/REMU semantics. It is the inverse-direction companion to the carry-lookahead adder: one restoring-division step per cycle, with each trial subtraction built from the existing `cla` (a + ~b + 1). It sits behind the datapath's M-extension dispatch and uses a valid/ready handshake on both sides.

---
 rtl/divider_iterative_pkg.sv | 26 ++
 rtl/divider_iterative_cla.sv | 47 ++++
 rtl/divider_iterative.sv | 136 +++++++++++++
 3 files changed

// File: rtl/divider_iterative_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// div_pkg : shared types, sizes and operand-magnitude helper for the divider
// rev 1.0
// ---------------------------------------------------------------------------
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITERS = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Magnitude of a two's-complement value; unsigned operands pass through.
  function automatic logic [DIV_WIDTH-1:0] div_mag(
    input logic [DIV_WIDTH-1:0] v,
    input logic                 is_signed
  );
    return (is_signed && v[DIV_WIDTH-1]) ? -v : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/divider_iterative_cla.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cla : carry-lookahead adder, 4-bit groups with lookahead group carry-out
// rev 1.0
// ---------------------------------------------------------------------------
module cla #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int C_GROUP = 4;

  logic [WIDTH-1:0] w_p;
  logic [WIDTH-1:0] w_g;
  logic [WIDTH:0]   w_c;

  always_comb begin
    logic gg;
    logic gp;
    w_p    = a ^ b;
    w_g    = a & b;
    w_c    = '0;
    w_c[0] = cin;
    for (int k = 0; k < WIDTH / C_GROUP; k++) begin
      gg = 1'b0;
      gp = 1'b1;
      for (int j = 0; j < C_GROUP; j++) begin
        gg = w_g[k*C_GROUP+j] | (w_p[k*C_GROUP+j] & gg);
        gp = gp & w_p[k*C_GROUP+j];
      end
      for (int j = 0; j < C_GROUP - 1; j++) begin
        w_c[k*C_GROUP+j+1] = w_g[k*C_GROUP+j] | (w_p[k*C_GROUP+j] & w_c[k*C_GROUP+j]);
      end
      w_c[(k+1)*C_GROUP] = gg | (gp & w_c[k*C_GROUP]);
    end
  end

  assign sum  = w_p ^ w_c[WIDTH-1:0];
  assign cout = w_c[WIDTH];

endmodule
`default_nettype wire

// File: rtl/divider_iterative.sv
`default_nettype none
// ---------------------------------------------------------------------------
// divider_iterative : 32-cycle restoring divider, RV32M DIV/DIVU/REM/REMU
// rev 1.0
// ---------------------------------------------------------------------------
module divider_iterative
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  input  logic             i_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder
);

  localparam logic [4:0] C_LAST = 5'(DIV_ITERS - 1);

  div_state_t       r_state;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quot;
  logic [4:0]       r_count;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dvs_zero;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;

  logic [WIDTH-1:0] w_r_low;
  logic [WIDTH-1:0] w_diff;
  logic             w_cout;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_quot_next;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;

  // Shifted remainder is 33 bits: r_rem's MSB sits above w_r_low.
  assign w_r_low = {r_rem[WIDTH-2:0], r_dvd[WIDTH-1]};

  cla #(
    .WIDTH (WIDTH)
  ) u_cla (
    .a    (w_r_low),
    .b    (~r_dvs),
    .cin  (1'b1),
    .sum  (w_diff),
    .cout (w_cout)
  );

  // No borrow out of the low word, or a set 33rd bit, means R >= divisor.
  assign w_ge        = r_rem[WIDTH-1] | w_cout;
  assign w_rem_next  = w_ge ? w_diff : w_r_low;
  assign w_quot_next = {r_quot[WIDTH-2:0], w_ge};

  // Zero divisor leaves |dividend| in the remainder, so only the quotient is forced.
  assign w_q_fix = r_dvs_zero ? '1 : (r_neg_q ? -w_quot_next : w_quot_next);
  assign w_r_fix = r_neg_r ? -w_rem_next : w_rem_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_rem       <= '0;
      r_quot      <= '0;
      r_count     <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_dvs_zero  <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_dvd      <= div_mag(i_dividend, i_signed);
            r_dvs      <= div_mag(i_divisor, i_signed);
            r_rem      <= '0;
            r_quot     <= '0;
            r_count    <= '0;
            r_neg_q    <= i_signed & (i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1]);
            r_neg_r    <= i_signed & i_dividend[WIDTH-1];
            r_dvs_zero <= (i_divisor == '0);
            r_in_ready <= 1'b0;
            r_state    <= BUSY;
          end
        end
        BUSY: begin
          r_dvd   <= {r_dvd[WIDTH-2:0], 1'b0};
          r_rem   <= w_rem_next;
          r_quot  <= w_quot_next;
          r_count <= r_count + 5'd1;
          if (r_count == C_LAST) begin
            r_quotient  <= w_q_fix;
            r_remainder <= w_r_fix;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign o_quotient  = r_quotient;
  assign o_remainder = r_remainder;

endmodule
`default_nettype wire
